button_press_classifier: RTL and testbench
==========================================

# button_press_classifier

Downstream consumer of the early debouncer's `db` output. It classifies each debounced press as short or long, and can optionally emit auto-repeat events while a long press is held. Each press produces single-cycle event ticks and a wrapping press counter for user-interface control logic. It runs entirely in the debouncer's clock domain; `db` is treated as already synchronous and glitch-free.

## Interface
- `LONG_CYCLES`, default 50_000_000: consecutive high samples of `db` that qualify a press as long; legal range is ≥ 2.
- `REPEAT_CYCLES`, default 10_000_000: auto-repeat period in samples while held past the long threshold; legal range is ≥ 1.
- `CNT_W`, default 8: width of `press_count`.
- `clk` in 1: system clock; all logic is on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `db` in 1: debounced switch level; 1 = pressed.
- `short_tick` out 1: one-cycle pulse for a completed short press.
- `long_tick` out 1: one-cycle pulse when the long threshold is reached.
- `rpt_tick` out 1: one-cycle auto-repeat pulse. Tied to 0 when the feature is compiled out.
- `press_count` out CNT_W: count of `short_tick`, `long_tick` and `rpt_tick` events, wrapping modulo 2^CNT_W.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States:
  - WAIT_REL: reset state.
  - IDLE.
  - PRESSED.
  - LONG.
- Hold counter:
  - `hold_cnt` has width $clog2(LONG_CYCLES+1), or wider if the repeat counter needs it.
  - It counts consecutive high samples of `db` within the current press.
- WAIT_REL:
  - Go to IDLE on the first sample with `db`=0.
  - A press already in progress when reset is released generates no events.
- IDLE:
  - `db`=1 → PRESSED with `hold_cnt`=1.
  - `db`=0 → stay in IDLE.
- PRESSED:
  - `db`=1 and `hold_cnt`=LONG_CYCLES-1 → LONG, assert `long_tick`, increment `press_count`.
  - `db`=1 otherwise → `hold_cnt` increments.
  - `db`=0 → IDLE, assert `short_tick`, increment `press_count`.
- LONG:
  - `db`=0 → IDLE with no tick.
  - `db`=1 → repeat counter behaviour is defined under Configuration.
- Release and re-press:
  - A press re-entering IDLE can start a new press on the very next high sample.
  - There is no mandatory low gap beyond a single sample.
- Exclusivity:
  - At most one of `short_tick`, `long_tick` and `rpt_tick` is high in any cycle.
  - `press_count` increments by exactly 1 per tick and wraps from 2^CNT_W-1 to 0.
- Reset mid-press:
  - All counters and outputs clear.
  - State goes to WAIT_REL, so no tick is produced for the interrupted press.

## Timing
- All outputs are registered.
- Reset values (`reset`=0 sampled at an edge):
  - `short_tick`=0, `long_tick`=0, `rpt_tick`=0, `press_count`=0.
  - `busy`=1, because the state is WAIT_REL.
- Sample numbering: sample k is the k-th consecutive rising edge at which `db`=1, starting from IDLE.
- `long_tick`:
  - High during the cycle following sample LONG_CYCLES.
  - Requires samples 1..LONG_CYCLES to all be high.
- `short_tick`:
  - High during the cycle following the first low sample.
  - Applies only when the press lasted H samples with 1 ≤ H ≤ LONG_CYCLES-1.
- Exact threshold: H = LONG_CYCLES produces `long_tick` only and no `short_tick`.
- `rpt_tick`: high during the cycle following sample LONG_CYCLES + m·REPEAT_CYCLES, for m ≥ 1.
- `press_count` updates on the same edge that raises the corresponding tick.
- `busy` is registered state decode. It goes high the cycle after sample 1 and low the cycle after the releasing low sample.

## Configuration
- Macro: `BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN`.
- Defined:
  - In LONG, a repeat counter counts high samples from 1 to REPEAT_CYCLES.
  - When it reaches REPEAT_CYCLES it pulses `rpt_tick`, increments `press_count` and restarts at 1.
  - It clears on exit from LONG.
- Undefined:
  - The repeat counter is not synthesized.
  - `rpt_tick` is constant 0.
  - LONG waits only for release.

## Test plan
All scenarios use a 20 ns clock, LONG_CYCLES=8, REPEAT_CYCLES=4 and CNT_W=3.
- **Reset with button held:** hold `reset`=0 for 2 cycles with `db`=1, release reset, keep `db`=1 for 20 cycles, then drop it → no ticks, `press_count`=0, `busy` falls after the low sample.
- **Short press:** `db`=1 for 3 samples then 0 → one `short_tick` in the cycle after the first low sample, no `long_tick`, `press_count`=1.
- **Threshold boundary:** `db`=1 for exactly 7 samples → `short_tick`. `db`=1 for exactly 8 samples → `long_tick` after sample 8, no `short_tick`.
- **Long press with auto-repeat, macro defined:** `db`=1 for 20 samples → `long_tick` after sample 8, `rpt_tick` after samples 12, 16 and 20, `press_count`=4. With the macro undefined the same stimulus gives `long_tick` only and `press_count`=1.
- **Counter wrap:** 9 consecutive short presses with a 1-sample low gap between them → `press_count` reads 7 after the 7th press, 0 after the 8th and 1 after the 9th.
- **Reset mid-press:** assert `reset`=0 at sample 5 of a press, release it, then drop `db` 3 cycles later → no `short_tick`, `press_count`=0, state returns to IDLE.

Source files
------------

// File: rtl/button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module  : button_press_classifier
// Brief   : Classifies debounced presses as short/long, with optional
//           auto-repeat enabled by BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN.
// Revision: 1.0
// ============================================================================
module button_press_classifier #(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             db,
    output logic             short_tick,
    output logic             long_tick,
    output logic             rpt_tick,
    output logic [CNT_W-1:0] press_count,
    output logic             busy
);

    localparam int LW = $clog2(LONG_CYCLES + 1);
    localparam int RW = $clog2(REPEAT_CYCLES + 1);
    localparam int HW = (LW > RW) ? LW : RW;
    localparam logic [HW-1:0] c_LONG_M1 = HW'(LONG_CYCLES - 1);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,
        IDLE     = 2'd1,
        PRESSED  = 2'd2,
        LONG     = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [HW-1:0]    r_hold;
    logic [HW-1:0]    w_hold_nxt;
    logic             w_short;
    logic             w_long;
    logic             w_any;
    logic             r_short;
    logic             r_long;
    logic [CNT_W-1:0] r_cnt;
    logic             r_busy;

`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
    localparam logic [HW-1:0] c_REP_M1 = HW'(REPEAT_CYCLES - 1);
    logic w_rpt;
    logic r_rpt;
`endif

    // In LONG the hold counter is reused as the repeat counter, holding
    // (samples into the current repeat period - 1).
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_short     = 1'b0;
        w_long      = 1'b0;
`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
        w_rpt       = 1'b0;
`endif
        case (r_state)
            WAIT_REL: begin
                if (!db) w_state_nxt = IDLE;
            end
            IDLE: begin
                if (db) begin
                    w_state_nxt = PRESSED;
                    w_hold_nxt  = HW'(1);
                end
            end
            PRESSED: begin
                if (!db) begin
                    w_state_nxt = IDLE;
                    w_short     = 1'b1;
                    w_hold_nxt  = '0;
                end else if (r_hold == c_LONG_M1) begin
                    w_state_nxt = LONG;
                    w_long      = 1'b1;
                    w_hold_nxt  = '0;
                end else begin
                    w_hold_nxt  = r_hold + HW'(1);
                end
            end
            LONG: begin
                if (!db) begin
                    w_state_nxt = IDLE;
                    w_hold_nxt  = '0;
                end
`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
                else if (r_hold == c_REP_M1) begin
                    w_rpt      = 1'b1;
                    w_hold_nxt = '0;
                end else begin
                    w_hold_nxt = r_hold + HW'(1);
                end
`endif
            end
            default: begin
                w_state_nxt = WAIT_REL;
                w_hold_nxt  = '0;
            end
        endcase
    end

`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
    assign w_any = w_short | w_long | w_rpt;
`else
    assign w_any = w_short | w_long;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= WAIT_REL;
            r_hold  <= '0;
            r_short <= 1'b0;
            r_long  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_short <= w_short;
            r_long  <= w_long;
            r_cnt   <= r_cnt + CNT_W'(w_any);
            r_busy  <= (w_state_nxt != IDLE);
        end
    end

`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
    always_ff @(posedge clk) begin
        if (!reset) r_rpt <= 1'b0;
        else        r_rpt <= w_rpt;
    end
    assign rpt_tick = r_rpt;
`else
    assign rpt_tick = 1'b0;
`endif

    assign short_tick  = r_short;
    assign long_tick   = r_long;
    assign press_count = r_cnt;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_button_press_classifier.sv
`default_nettype none
// ============================================================================
// Module  : tb_button_press_classifier
// Brief   : Scoreboard bench; LONG_CYCLES=8, REPEAT_CYCLES=4, CNT_W=3.
// Revision: 1.0
// ============================================================================
module tb_button_press_classifier;

    localparam int LONG_C = 8;
    localparam int REP_C  = 4;
    localparam int CW     = 3;

    logic          clk;
    logic          reset;
    logic          db;
    logic          short_tick;
    logic          long_tick;
    logic          rpt_tick;
    logic [CW-1:0] press_count;
    logic          busy;

    button_press_classifier #(
        .LONG_CYCLES  (LONG_C),
        .REPEAT_CYCLES(REP_C),
        .CNT_W        (CW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .db         (db),
        .short_tick (short_tick),
        .long_tick  (long_tick),
        .rpt_tick   (rpt_tick),
        .press_count(press_count),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Vector layout: {short, long, rpt, count[2:0], busy}
    logic [6:0]    exp_q[$];
    logic [6:0]    obs_q[$];
    logic [CW-1:0] exp_cnt;
    int            n_vec;
    int            n_err;

    task automatic step(input logic rn, input logic v, input logic [6:0] e);
        reset = rn;
        db    = v;
        @(posedge clk);
        #1;
        exp_q.push_back(e);
        obs_q.push_back({short_tick, long_tick, rpt_tick, press_count, busy});
    endtask

    // Press of h high samples from IDLE followed by lo low samples.
    task automatic press(input int h, input int lo);
        logic l, r, s;
        for (int k = 1; k <= h; k++) begin
            l = (k == LONG_C);
`ifdef BUTTON_PRESS_CLASSIFIER_AUTO_REPEAT_EN
            r = (k > LONG_C) && (((k - LONG_C) % REP_C) == 0);
`else
            r = 1'b0;
`endif
            if (l || r) exp_cnt = exp_cnt + 1'b1;
            step(1'b1, 1'b1, {1'b0, l, r, exp_cnt, 1'b1});
        end
        for (int k = 0; k < lo; k++) begin
            s = (k == 0) && (h < LONG_C);
            if (s) exp_cnt = exp_cnt + 1'b1;
            step(1'b1, 1'b0, {s, 1'b0, 1'b0, exp_cnt, 1'b0});
        end
    endtask

    task automatic clear_to_idle();
        exp_cnt = '0;
        step(1'b0, 1'b0, {3'b000, 3'd0, 1'b1});
        step(1'b1, 1'b0, {3'b000, 3'd0, 1'b0});
    endtask

    task automatic test_reset();
        logic [6:0] e, o;
        exp_cnt = '0;
        for (int i = 0; i < 2; i++) step(1'b0, 1'b1, {3'b000, 3'd0, 1'b1});
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1, {3'b000, 3'd0, 1'b1});
        step(1'b1, 1'b0, {3'b000, 3'd0, 1'b0});
        step(1'b1, 1'b0, {3'b000, 3'd0, 1'b0});
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_held: got s/l/r/cnt/busy=%b required %b", o, e);
            end
        end
    endtask

    task automatic test_short();
        logic [6:0] e, o;
        press(3, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL short_press: got s/l/r/cnt/busy=%b required %b", o, e);
            end
        end
    endtask

    task automatic test_threshold();
        logic [6:0] e, o;
        press(LONG_C - 1, 1);
        press(LONG_C, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL threshold: got s/l/r/cnt/busy=%b required %b", o, e);
            end
        end
    endtask

    task automatic test_long_repeat();
        logic [6:0] e, o;
        clear_to_idle();
        press(20, 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL long_repeat: got s/l/r/cnt/busy=%b required %b", o, e);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [6:0] e, o;
        clear_to_idle();
        for (int i = 0; i < 9; i++) press(2, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL count_wrap: got s/l/r/cnt/busy=%b required %b", o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [6:0] e, o;
        clear_to_idle();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, {3'b000, 3'd0, 1'b1});
        step(1'b0, 1'b1, {3'b000, 3'd0, 1'b1});
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, {3'b000, 3'd0, 1'b1});
        step(1'b1, 1'b0, {3'b000, 3'd0, 1'b0});
        step(1'b1, 1'b0, {3'b000, 3'd0, 1'b0});
        exp_cnt = '0;
        press(2, 1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            n_vec++;
            if (o !== e) begin
                n_err++;
                $display("FAIL reset_mid: got s/l/r/cnt/busy=%b required %b", o, e);
            end
        end
    endtask

    initial begin
        reset   = 1'b0;
        db      = 1'b0;
        exp_cnt = '0;
        n_vec   = 0;
        n_err   = 0;
        test_reset();
        test_short();
        test_threshold();
        test_long_repeat();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
